// File: rtl/ddr5_sched_pkg.sv
// Shared types and defaults for the DDR5 scheduler timing tracker.
// Holds the command and bank-state encodings, the default timing set, and
// the counter helpers used by the bank timers and the top-level tracker.
package ddr5_sched_pkg;

   typedef enum logic [2:0] {
      NOP = 3'd0,
      ACT = 3'd1,
      RD  = 3'd2,
      WR  = 3'd3,
      PRE = 3'd4,
      REF = 3'd5
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      REFRESH = 2'd2
   } bank_state_e;

   localparam int unsigned DEF_T_RCD       = 76;
   localparam int unsigned DEF_T_RP        = 74;
   localparam int unsigned DEF_T_RAS       = 152;
   localparam int unsigned DEF_T_RC        = 226;
   localparam int unsigned DEF_T_RTP       = 36;
   localparam int unsigned DEF_T_WR        = 60;
   localparam int unsigned DEF_T_CWD       = 76;
   localparam int unsigned DEF_T_BURST     = 16;
   localparam int unsigned DEF_T_RFC       = 710;
   localparam int unsigned DEF_T_RRD_L     = 22;
   localparam int unsigned DEF_T_RRD_S     = 14;
   localparam int unsigned DEF_T_CCD_L     = 22;
   localparam int unsigned DEF_T_CCD_S     = 14;
   localparam int unsigned DEF_T_CCD_L_WR  = 94;
   localparam int unsigned DEF_T_CCD_S_WR  = 14;
   localparam int unsigned DEF_T_CCD_L_RTW = 30;
   localparam int unsigned DEF_T_CCD_S_RTW = 30;
   localparam int unsigned DEF_T_CCD_L_WTR = 138;
   localparam int unsigned DEF_T_CCD_S_WTR = 102;

   function automatic int unsigned max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // One cycle of a timing down-counter: saturate at 0, and on a load never
   // shorten a wait that is already pending. Loading T-1 makes the dependent
   // ok bit rise exactly T cycles after the command.
   function automatic int unsigned next_cnt(input int unsigned cnt, input logic load,
                                            input int unsigned t);
      int unsigned dec;
      dec = (cnt == 0) ? 0 : cnt - 1;
      return load ? max(dec, t - 1) : dec;
   endfunction

endpackage

// File: rtl/ddr5_bank_timer.sv
// Single-bank state machine and bank-local timing counters.
// Tracks IDLE/ACTIVE/REFRESH and the waits that belong to one bank:
// ACT->RD/WR, ACT->PRE, ACT->ACT, PRE->ACT and the read/write-to-PRE delay.
module ddr5_bank_timer
   import ddr5_sched_pkg::*;
#(
   parameter int unsigned CNT_W  = 10,
   parameter int unsigned T_RCD  = DEF_T_RCD,
   parameter int unsigned T_RAS  = DEF_T_RAS,
   parameter int unsigned T_RC   = DEF_T_RC,
   parameter int unsigned T_RP   = DEF_T_RP,
   parameter int unsigned T_RTP  = DEF_T_RTP,
   parameter int unsigned T_WPRE = DEF_T_CWD + DEF_T_BURST + DEF_T_WR
) (
   input  logic clk,
   input  logic rst_n,
   input  logic act_cmd,
   input  logic pre_cmd,
   input  logic rd_cmd,
   input  logic wr_cmd,
   input  logic ref_cmd,
   input  logic ref_done,
   output logic act_ready,
   output logic rdwr_ready,
   output logic pre_ready,
   output logic is_open
);

   bank_state_e      state;
   logic [CNT_W-1:0] rcd_cnt;
   logic [CNT_W-1:0] ras_cnt;
   logic [CNT_W-1:0] rc_cnt;
   logic [CNT_W-1:0] rp_cnt;
   logic [CNT_W-1:0] pdly_cnt;
   logic             eff_idle;

   // Bank state: commands move the bank even when issued illegally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (act_cmd) begin
         state <= ACTIVE;
      end else if (pre_cmd) begin
         state <= IDLE;
      end else if (ref_cmd) begin
         state <= REFRESH;
      end else if (state == REFRESH && ref_done) begin
         state <= IDLE;
      end
   end

   // Bank-local timing counters; RD and WR share the delay that gates PRE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcd_cnt  <= '0;
         ras_cnt  <= '0;
         rc_cnt   <= '0;
         rp_cnt   <= '0;
         pdly_cnt <= '0;
      end else begin
         rcd_cnt <= CNT_W'(next_cnt(32'(rcd_cnt), act_cmd, T_RCD));
         ras_cnt <= CNT_W'(next_cnt(32'(ras_cnt), act_cmd, T_RAS));
         rc_cnt  <= CNT_W'(next_cnt(32'(rc_cnt), act_cmd, T_RC));
         rp_cnt  <= CNT_W'(next_cnt(32'(rp_cnt), pre_cmd, T_RP));
         if (wr_cmd) begin
            pdly_cnt <= CNT_W'(next_cnt(32'(pdly_cnt), 1'b1, T_WPRE));
         end else begin
            pdly_cnt <= CNT_W'(next_cnt(32'(pdly_cnt), rd_cmd, T_RTP));
         end
      end
   end

   // A refreshing bank counts as idle in the very cycle tRFC runs out.
   assign eff_idle   = (state == IDLE) || (state == REFRESH && ref_done);
   assign act_ready  = eff_idle && (rc_cnt == '0) && (rp_cnt == '0);
   assign rdwr_ready = (state == ACTIVE) && (rcd_cnt == '0);
   assign pre_ready  = (state == ACTIVE) && (ras_cnt == '0) && (pdly_cnt == '0);
   assign is_open    = (state == ACTIVE);

endmodule

// File: rtl/ddr5_bank_timing_tracker.sv
// Per-bank DDR5 timing tracker: observes issued commands and presents the
// per-bank "legal now" vectors used by the scheduler.
// Bank-local waits live in ddr5_bank_timer; bank-group waits (ACT->ACT,
// column-to-column and turnarounds) are held per bank group here, each group
// loading the long or short value depending on whether the command hit it.
// Optional: define DDR5_TIMING_ERR_EN to add the sticky illegal-command flag.
module ddr5_bank_timing_tracker
   import ddr5_sched_pkg::*;
#(
   parameter int unsigned NUM_BG       = 8,
   parameter int unsigned BANKS_PER_BG = 4,
   parameter int unsigned CNT_W        = 10,
   parameter int unsigned T_RCD        = DEF_T_RCD,
   parameter int unsigned T_RP         = DEF_T_RP,
   parameter int unsigned T_RAS        = DEF_T_RAS,
   parameter int unsigned T_RC         = DEF_T_RC,
   parameter int unsigned T_RTP        = DEF_T_RTP,
   parameter int unsigned T_WR         = DEF_T_WR,
   parameter int unsigned T_CWD        = DEF_T_CWD,
   parameter int unsigned T_BURST      = DEF_T_BURST,
   parameter int unsigned T_RFC        = DEF_T_RFC,
   parameter int unsigned T_RRD_L      = DEF_T_RRD_L,
   parameter int unsigned T_RRD_S      = DEF_T_RRD_S,
   parameter int unsigned T_CCD_L      = DEF_T_CCD_L,
   parameter int unsigned T_CCD_S      = DEF_T_CCD_S,
   parameter int unsigned T_CCD_L_WR   = DEF_T_CCD_L_WR,
   parameter int unsigned T_CCD_S_WR   = DEF_T_CCD_S_WR,
   parameter int unsigned T_CCD_L_RTW  = DEF_T_CCD_L_RTW,
   parameter int unsigned T_CCD_S_RTW  = DEF_T_CCD_S_RTW,
   parameter int unsigned T_CCD_L_WTR  = DEF_T_CCD_L_WTR,
   parameter int unsigned T_CCD_S_WTR  = DEF_T_CCD_S_WTR
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                cmd_valid,
   input  logic [2:0]                          cmd_type,
   input  logic [$clog2(NUM_BG)-1:0]           cmd_bg,
   input  logic [$clog2(BANKS_PER_BG)-1:0]     cmd_ba,
   output logic [NUM_BG*BANKS_PER_BG-1:0]      act_ok,
   output logic [NUM_BG*BANKS_PER_BG-1:0]      rd_ok,
   output logic [NUM_BG*BANKS_PER_BG-1:0]      wr_ok,
   output logic [NUM_BG*BANKS_PER_BG-1:0]      pre_ok,
   output logic                                ref_ok,
   output logic [NUM_BG*BANKS_PER_BG-1:0]      bank_open,
   output logic                                timing_err,
   output logic [2:0]                          err_code
);

   localparam int unsigned NB   = NUM_BG * BANKS_PER_BG;
   localparam int unsigned BG_W = $clog2(NUM_BG);
   localparam int unsigned BA_W = $clog2(BANKS_PER_BG);

   logic             is_act;
   logic             is_rd;
   logic             is_wr;
   logic             is_pre;
   logic             is_ref;
   logic             ref_done;
   logic [CNT_W-1:0] ref_cnt;
   logic [CNT_W-1:0] act_cnt [NUM_BG];
   logic [CNT_W-1:0] rd_cnt  [NUM_BG];
   logic [CNT_W-1:0] wr_cnt  [NUM_BG];
   logic [NB-1:0]    act_ready;
   logic [NB-1:0]    rdwr_ready;
   logic [NB-1:0]    pre_ready;

   assign is_act   = cmd_valid && (cmd_type == ACT);
   assign is_rd    = cmd_valid && (cmd_type == RD);
   assign is_wr    = cmd_valid && (cmd_type == WR);
   assign is_pre   = cmd_valid && (cmd_type == PRE);
   assign is_ref   = cmd_valid && (cmd_type == REF);
   assign ref_done = (ref_cnt == '0);

   // Refresh window: blocks every ACT until tRFC has elapsed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt <= '0;
      end else begin
         ref_cnt <= CNT_W'(next_cnt(32'(ref_cnt), is_ref, T_RFC));
      end
   end

   // Bank-group counters: act_cnt gates ACT, rd_cnt gates RD (after RD or
   // WR), wr_cnt gates WR (after WR or RD); long value for the hit group.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int h = 0; h < NUM_BG; h++) begin
            act_cnt[h] <= '0;
            rd_cnt[h]  <= '0;
            wr_cnt[h]  <= '0;
         end
      end else begin
         for (int h = 0; h < NUM_BG; h++) begin
            act_cnt[h] <= CNT_W'(next_cnt(32'(act_cnt[h]), is_act,
                                          (cmd_bg == BG_W'(h)) ? T_RRD_L : T_RRD_S));
            if (is_wr) begin
               rd_cnt[h] <= CNT_W'(next_cnt(32'(rd_cnt[h]), 1'b1,
                                            (cmd_bg == BG_W'(h)) ? T_CCD_L_WTR : T_CCD_S_WTR));
               wr_cnt[h] <= CNT_W'(next_cnt(32'(wr_cnt[h]), 1'b1,
                                            (cmd_bg == BG_W'(h)) ? T_CCD_L_WR : T_CCD_S_WR));
            end else begin
               rd_cnt[h] <= CNT_W'(next_cnt(32'(rd_cnt[h]), is_rd,
                                            (cmd_bg == BG_W'(h)) ? T_CCD_L : T_CCD_S));
               wr_cnt[h] <= CNT_W'(next_cnt(32'(wr_cnt[h]), is_rd,
                                            (cmd_bg == BG_W'(h)) ? T_CCD_L_RTW : T_CCD_S_RTW));
            end
         end
      end
   end

   for (genvar b = 0; b < NB; b++) begin : g_bank
      localparam int unsigned BG = b / BANKS_PER_BG;
      localparam int unsigned BA = b % BANKS_PER_BG;
      logic hit;

      assign hit = (cmd_bg == BG_W'(BG)) && (cmd_ba == BA_W'(BA));

      ddr5_bank_timer #(
         .CNT_W (CNT_W),
         .T_RCD (T_RCD),
         .T_RAS (T_RAS),
         .T_RC  (T_RC),
         .T_RP  (T_RP),
         .T_RTP (T_RTP),
         .T_WPRE(T_CWD + T_BURST + T_WR)
      ) u_timer (
         .clk       (clk),
         .rst_n     (rst_n),
         .act_cmd   (is_act && hit),
         .pre_cmd   (is_pre && hit),
         .rd_cmd    (is_rd && hit),
         .wr_cmd    (is_wr && hit),
         .ref_cmd   (is_ref),
         .ref_done  (ref_done),
         .act_ready (act_ready[b]),
         .rdwr_ready(rdwr_ready[b]),
         .pre_ready (pre_ready[b]),
         .is_open   (bank_open[b])
      );

      assign act_ok[b] = act_ready[b] && (act_cnt[BG] == '0) && ref_done;
      assign rd_ok[b]  = rdwr_ready[b] && (rd_cnt[BG] == '0);
      assign wr_ok[b]  = rdwr_ready[b] && (wr_cnt[BG] == '0);
      assign pre_ok[b] = pre_ready[b];
   end

   // REF needs every bank idle with its tRP/tRC waits finished.
   assign ref_ok = &act_ready;

`ifdef DDR5_TIMING_ERR_EN
   localparam int unsigned IDX_W = $clog2(NB);

   logic             illegal;
   logic [IDX_W-1:0] flat_idx;

   // An issued command whose ok bit is clear is illegal.
   always_comb begin
      flat_idx = IDX_W'(32'(cmd_bg) * BANKS_PER_BG + 32'(cmd_ba));
      illegal  = (is_act && !act_ok[flat_idx]) ||
                 (is_rd  && !rd_ok[flat_idx])  ||
                 (is_wr  && !wr_ok[flat_idx])  ||
                 (is_pre && !pre_ok[flat_idx]) ||
                 (is_ref && !ref_ok);
   end

   // Sticky capture of the first illegal command type.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timing_err <= 1'b0;
         err_code   <= 3'd0;
      end else if (illegal && !timing_err) begin
         timing_err <= 1'b1;
         err_code   <= cmd_type;
      end
   end

   // Report every illegal command as it is observed.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!illegal)
         else $warning("ddr5_bank_timing_tracker: illegal command type %0d to bg %0d ba %0d",
                       cmd_type, cmd_bg, cmd_ba);
      end
   end
`else
   assign timing_err = 1'b0;
   assign err_code   = 3'd0;
`endif

endmodule
